// File: rtl/teamplayer_n.sv
`default_nettype none
// ============================================================================
// teamplayer_n : Team Player style multitap engine serving NPADS sub-pads
//                through one controller port via the TH/TR/TL nibble handshake.
// Revision     : 1.0
// ============================================================================
module teamplayer_n #(
  parameter int NPADS   = 4,
  parameter int ACK_DLY = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CE,
  input  logic                  PORT,
  input  logic                  SEL,
  input  logic [4:1]            A,
  input  logic                  RNW,
  input  logic [7:0]            DI,
  output logic [7:0]            DO,
  output logic                  DTACK_N,
  input  logic [12*NPADS-1:0]   PAD,
  input  logic [2*NPADS-1:0]    PAD_TYPE
);

  localparam int c_IDX_MAX = 4 + 4*NPADS;
  localparam int c_IDXW    = $clog2(c_IDX_MAX + 1);
  localparam int c_CNTW    = $clog2(ACK_DLY + 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FRAME = 1'b1
  } state_t;

  state_t                r_state;
  logic [6:0]            r_data;
  logic [6:0]            r_ctrl;
  logic [c_IDXW-1:0]     r_idx;
  logic [c_CNTW-1:0]     r_cnt;
  logic                  r_pending;
  logic                  r_tl;
  logic                  r_tr_prev;
  logic [3:0]            r_nib;
  logic [12*NPADS-1:0]   r_snap_pad;
  logic [2*NPADS-1:0]    r_snap_type;

  logic                  w_th;
  logic                  w_tr;
  logic                  w_data_adr;
  logic                  w_ctrl_adr;
  logic [3:0]            w_nib;
  logic                  w_unused;

  assign w_th       = r_ctrl[6] ? r_data[6] : 1'b1;
  assign w_tr       = r_ctrl[5] ? r_data[5] : 1'b1;
  assign w_data_adr = (A == (PORT ? 4'd2 : 4'd1));
  assign w_ctrl_adr = (A == (PORT ? 4'd5 : 4'd4));
  assign w_unused   = ^{DI[7], r_data[4:0]};

  // Active-low button nibble k (0..2) of one pad.
  function automatic logic [3:0] f_pad_nib(input logic [11:0] p, input int k);
    logic [3:0] n;
    case (k)
      0:       n = ~{p[3], p[2], p[1], p[0]};
      1:       n = ~{p[7], p[4], p[6], p[5]};
      default: n = ~{p[8], p[9], p[10], p[11]};
    endcase
    return n;
  endfunction

  // Nibble at sequence position ii, walking the variable-length data section.
  function automatic logic [3:0] f_nibble(input int ii,
                                          input logic [12*NPADS-1:0] pads,
                                          input logic [2*NPADS-1:0] types);
    logic [3:0] nib;
    int         pos;
    int         k;
    nib = 4'hF;
    pos = 4 + NPADS;
    if (ii == 0) begin
      nib = 4'h3;
    end else if (ii == 1) begin
      nib = 4'hF;
    end else if (ii < 4) begin
      nib = 4'h0;
    end else if (ii < 4 + NPADS) begin
      for (int q = 0; q < NPADS; q++) begin
        if (ii == 4 + q) begin
          case (types[2*q +: 2])
            2'd1:    nib = 4'h0;
            2'd2:    nib = 4'h1;
            default: nib = 4'hF;
          endcase
        end
      end
    end else begin
      for (int q = 0; q < NPADS; q++) begin
        k = ii - pos;
        case (types[2*q +: 2])
          2'd1: begin
            if (k >= 0 && k < 2) nib = f_pad_nib(pads[12*q +: 12], k);
            pos = pos + 2;
          end
          2'd2: begin
            if (k >= 0 && k < 3) nib = f_pad_nib(pads[12*q +: 12], k);
            pos = pos + 3;
          end
          default: ;
        endcase
      end
    end
    return nib;
  endfunction

  always_comb begin
    w_nib = f_nibble(int'(r_idx), r_snap_pad, r_snap_type);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_data <= 7'h7F;
      r_ctrl <= 7'h00;
    end else if (SEL && !RNW) begin
      if (w_data_adr) r_data <= DI[6:0];
      if (w_ctrl_adr) r_ctrl <= DI[6:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      DO      <= 8'hFF;
      DTACK_N <= 1'b1;
    end else begin
      DTACK_N <= ~SEL;
      if (SEL && RNW) begin
        if (w_data_adr)      DO <= {1'b0, w_th, w_tr, r_tl, r_nib};
        else if (w_ctrl_adr) DO <= {1'b0, r_ctrl};
        else                 DO <= 8'hFF;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_pending   <= 1'b0;
      r_tl        <= 1'b1;
      r_tr_prev   <= 1'b1;
      r_nib       <= 4'h3;
      r_snap_pad  <= '0;
      r_snap_type <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_idx     <= '0;
          r_cnt     <= '0;
          r_pending <= 1'b0;
          r_tl      <= 1'b1;
          r_nib     <= 4'h3;
          if (!w_th) begin
            r_state     <= S_FRAME;
            r_tl        <= 1'b0;
            r_tr_prev   <= w_tr;
            r_snap_pad  <= PAD;
            r_snap_type <= PAD_TYPE;
          end
        end
        default: begin
          if (w_th) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_tl      <= 1'b1;
            r_nib     <= 4'h3;
          end else begin
            // Expiry is applied first; a TR edge in the same cycle overrides it.
            if (r_pending && CE) begin
              if (r_cnt == c_CNTW'(1)) begin
                r_nib     <= w_nib;
                r_tl      <= w_tr;
                r_pending <= 1'b0;
                r_cnt     <= '0;
              end else begin
                r_cnt <= r_cnt - c_CNTW'(1);
              end
            end
            if (w_tr != r_tr_prev) begin
              r_tr_prev <= w_tr;
              r_pending <= 1'b1;
              r_cnt     <= c_CNTW'(ACK_DLY);
              if (r_idx != c_IDXW'(c_IDX_MAX)) r_idx <= r_idx + c_IDXW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_teamplayer_n.sv
`default_nettype none
// ============================================================================
// tb_teamplayer_n : randomized bench for teamplayer_n against a nibble-list
//                   reference model, plus directed literal scenarios.
// Revision        : 1.0
// ============================================================================
module tb_teamplayer_n;

  localparam int NPADS   = 4;
  localparam int ACK_DLY = 3;
  localparam int IDX_MAX = 4 + 4*NPADS;

  logic                CLK = 1'b0;
  logic                RESET, CE, PORT, SEL, RNW;
  logic [4:1]          A;
  logic [7:0]          DI;
  logic [7:0]          DO;
  logic                DTACK_N;
  logic [12*NPADS-1:0] PAD;
  logic [2*NPADS-1:0]  PAD_TYPE;

  int total = 0;
  int bad   = 0;

  teamplayer_n #(.NPADS(NPADS), .ACK_DLY(ACK_DLY)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .PORT(PORT), .SEL(SEL), .A(A),
    .RNW(RNW), .DI(DI), .DO(DO), .DTACK_N(DTACK_N), .PAD(PAD), .PAD_TYPE(PAD_TYPE)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  logic [6:0] m_data, m_ctrl;
  logic [7:0] m_do;
  logic       m_dtack, m_tl, m_trp, m_th, m_tr;
  logic [3:0] m_nib;
  bit         m_valid = 0;
  bit         m_inframe;
  int         m_idx, m_cd, m_ad, m_ac;
  logic [3:0] m_seq[$];

  function automatic logic [3:0] seq_at(input int i);
    return (i < m_seq.size()) ? m_seq[i] : 4'hF;
  endfunction

  task automatic build_seq(input logic [12*NPADS-1:0] pads, input logic [2*NPADS-1:0] types);
    logic [11:0] p;
    logic [1:0]  t;
    m_seq = {4'h3, 4'hF, 4'h0, 4'h0};
    for (int q = 0; q < NPADS; q++) begin
      t = types[2*q +: 2];
      m_seq.push_back(t == 2'd1 ? 4'h0 : (t == 2'd2 ? 4'h1 : 4'hF));
    end
    for (int q = 0; q < NPADS; q++) begin
      t = types[2*q +: 2];
      p = pads[12*q +: 12];
      if (t == 2'd1 || t == 2'd2) begin
        m_seq.push_back(~{p[3], p[2], p[1], p[0]});   // RIGHT LEFT DOWN UP
        m_seq.push_back(~{p[7], p[4], p[6], p[5]});   // START A C B
        if (t == 2'd2) m_seq.push_back(~{p[8], p[9], p[10], p[11]}); // MODE X Y Z
      end
    end
  endtask

  always @(posedge CLK) begin
    m_th = m_ctrl[6] ? m_data[6] : 1'b1;
    m_tr = m_ctrl[5] ? m_data[5] : 1'b1;
    if (RESET) begin
      m_valid = 1; m_data = 7'h7F; m_ctrl = 7'h00; m_do = 8'hFF; m_dtack = 1'b1;
      m_inframe = 0; m_idx = 0; m_cd = 0; m_tl = 1'b1; m_nib = 4'h3; m_trp = 1'b1;
    end else begin
      m_ad = PORT ? 2 : 1;
      m_ac = PORT ? 5 : 4;
      if (SEL && RNW)
        m_do = (int'(A) == m_ad) ? {1'b0, m_th, m_tr, m_tl, m_nib} :
               (int'(A) == m_ac) ? {1'b0, m_ctrl} : 8'hFF;
      m_dtack = !SEL;
      if (!m_inframe) begin
        m_idx = 0; m_cd = 0; m_tl = 1'b1; m_nib = 4'h3;
        if (!m_th) begin
          m_inframe = 1; m_tl = 1'b0; m_trp = m_tr;
          build_seq(PAD, PAD_TYPE);
        end
      end else if (m_th) begin
        m_inframe = 0; m_idx = 0; m_cd = 0; m_tl = 1'b1; m_nib = 4'h3;
      end else begin
        if (m_cd > 0 && CE) begin
          m_cd--;
          if (m_cd == 0) begin m_nib = seq_at(m_idx); m_tl = m_tr; end
        end
        if (m_tr != m_trp) begin
          m_trp = m_tr;
          m_idx = (m_idx + 1 > IDX_MAX) ? IDX_MAX : m_idx + 1;
          m_cd  = ACK_DLY;
        end
      end
      if (SEL && !RNW) begin
        if (int'(A) == m_ad) m_data = DI[6:0];
        if (int'(A) == m_ac) m_ctrl = DI[6:0];
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", nm, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (m_valid && !RESET) begin
      chk("do_vs_model", DO, m_do);
      chk("dtack_vs_model", {7'b0, DTACK_N}, {7'b0, m_dtack});
    end
  end

  // ---------------- stimulus helpers ----------------
  logic tb_tr;
  logic [7:0] rdv;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic wr(input logic [4:1] a, input logic [7:0] d);
    SEL = 1'b1; RNW = 1'b0; A = a; DI = d;
    tick();
    SEL = 1'b0;
  endtask

  task automatic rd(input logic [4:1] a, output logic [7:0] d);
    SEL = 1'b1; RNW = 1'b1; A = a;
    tick();
    d = DO;
    SEL = 1'b0;
  endtask

  task automatic toggle();
    tb_tr = ~tb_tr;
    wr(4'd1, {2'b00, tb_tr, 5'b0});
    repeat (6) tick();
  endtask

  task automatic new_frame(input logic tr0);
    wr(4'd1, {2'b01, tr0, 5'b0});
    repeat (2) tick();
    wr(4'd1, {2'b00, tr0, 5'b0});
    repeat (3) tick();
    tb_tr = tr0;
  endtask

  logic [3:0] exp_nib [0:14];
  int r;

  initial begin
    exp_nib = '{4'h3, 4'hF, 4'h0, 4'h0, 4'h1, 4'h0, 4'hF, 4'h0,
                4'hE, 4'hF, 4'hB, 4'hF, 4'h7, 4'hF, 4'hF};
    RESET = 1'b1; CE = 1'b0; PORT = 1'b0; SEL = 1'b0; RNW = 1'b1;
    A = 4'd0; DI = 8'h00; PAD = '0; PAD_TYPE = '0; tb_tr = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    chk("reset_dtack", {7'b0, DTACK_N}, 8'h01);
    chk("reset_do", DO, 8'hFF);

    // Reset register views
    rd(4'd1, rdv); chk("reset_data_read", rdv, 8'h73);
    rd(4'd4, rdv); chk("reset_ctrl_read", rdv, 8'h00);
    rd(4'd3, rdv); chk("other_addr_read", rdv, 8'hFF);

    // Full frame walk, types {6btn,3btn,none,3btn}
    CE = 1'b1;
    PAD      = {12'h000, 12'hFFF, 12'h080, 12'h201};
    PAD_TYPE = 8'b01_00_01_10;
    wr(4'd4, 8'h60);
    wr(4'd1, 8'h20);
    repeat (3) tick();
    tb_tr = 1'b1;
    rd(4'd1, rdv); chk("frame_start", rdv, 8'h23);
    for (int i = 1; i <= 22; i++) begin
      toggle();
      rd(4'd1, rdv);
      chk($sformatf("frame_nib%0d", i), rdv,
          {2'b00, tb_tr, tb_tr, (i <= 14) ? exp_nib[i] : 4'hF});
    end
    wr(4'd1, 8'h60);
    repeat (3) tick();

    // Ack timing with CE every second clock
    CE = 1'b0;
    new_frame(1'b0);
    CE = 1'b1; SEL = 1'b1; RNW = 1'b0; A = 4'd1; DI = 8'h20;
    tick();
    SEL = 1'b1; RNW = 1'b1; A = 4'd1;
    for (int j = 1; j <= 8; j++) begin
      CE = (j % 2 == 0);
      tick();
      chk($sformatf("ack_dly_clk%0d", j), DO, (j <= 6) ? 8'h23 : 8'h3F);
    end
    SEL = 1'b0; CE = 1'b0;
    wr(4'd1, 8'h60);
    repeat (3) tick();

    // Snapshot coherence
    CE = 1'b1;
    new_frame(1'b1);
    for (int i = 1; i <= 7; i++) toggle();
    PAD = {12'hFFF, 12'hFFF, 12'hFFF, 12'h000};
    toggle(); rd(4'd1, rdv); chk("snap_pad0_n0", {4'h0, rdv[3:0]}, 8'h0E);
    toggle(); toggle(); rd(4'd1, rdv); chk("snap_pad0_n2", {4'h0, rdv[3:0]}, 8'h0B);
    toggle(); toggle(); rd(4'd1, rdv); chk("snap_pad1_n1", {4'h0, rdv[3:0]}, 8'h07);
    wr(4'd1, 8'h60);
    repeat (3) tick();
    new_frame(1'b1);
    for (int i = 1; i <= 8; i++) toggle();
    rd(4'd1, rdv); chk("next_frame_pad0_n0", {4'h0, rdv[3:0]}, 8'h0F);
    for (int i = 1; i <= 4; i++) toggle();
    rd(4'd1, rdv); chk("next_frame_pad1_n1", {4'h0, rdv[3:0]}, 8'h00);
    wr(4'd1, 8'h60);
    repeat (3) tick();

    // Two TR edges one CE apart
    CE = 1'b0;
    new_frame(1'b0);
    wr(4'd1, 8'h20);
    tick();
    CE = 1'b1; tick(); CE = 1'b0;
    wr(4'd1, 8'h00);
    tick();
    CE = 1'b1; tick(); tick(); CE = 1'b0;
    rd(4'd1, rdv); chk("double_edge_pending", rdv, 8'h03);
    CE = 1'b1; tick(); CE = 1'b0;
    rd(4'd1, rdv); chk("double_edge_ack", rdv, 8'h00);
    wr(4'd1, 8'h60);
    repeat (3) tick();

    // Reset mid-frame at IDX=6
    CE = 1'b1;
    new_frame(1'b1);
    for (int i = 1; i <= 6; i++) toggle();
    RESET = 1'b1; tick(); RESET = 1'b0;
    rd(4'd1, rdv); chk("midframe_reset_data", rdv, 8'h73);
    rd(4'd4, rdv); chk("midframe_reset_ctrl", rdv, 8'h00);
    wr(4'd4, 8'h60);
    wr(4'd1, 8'h00);
    repeat (3) tick();
    rd(4'd1, rdv); chk("restart_frame", rdv, 8'h03);
    tb_tr = 1'b0;
    toggle();
    rd(4'd1, rdv); chk("restart_first_ack", rdv, 8'h3F);

    // Randomized traffic checked cycle by cycle against the model
    for (int it = 0; it < 3000; it++) begin
      CE = ($urandom_range(0, 2) != 0);
      r  = $urandom_range(0, 99);
      if (r < 35) begin
        wr(PORT ? 4'd2 : 4'd1, {1'($urandom), ($urandom_range(0, 9) == 0),
                                1'($urandom), 5'($urandom)});
      end else if (r < 40) begin
        wr(PORT ? 4'd5 : 4'd4, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h60);
      end else if (r < 45) begin
        wr(4'($urandom), 8'($urandom));
      end else if (r < 75) begin
        rd(($urandom_range(0, 3) == 0) ? 4'($urandom) : (PORT ? 4'd2 : 4'd1), rdv);
      end else if (r < 80) begin
        PAD = 48'({$urandom(), $urandom()});
        for (int q = 0; q < NPADS; q++) PAD_TYPE[2*q +: 2] = 2'($urandom_range(0, 3));
        tick();
      end else if (r < 81) begin
        RESET = 1'b1; tick(); RESET = 1'b0;
      end else if (r < 83) begin
        PORT = ~PORT; tick();
      end else begin
        tick();
      end
    end

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
